btb_update_gen: RTL and testbench
=================================

# btb_update_gen

Update generator for the two-bank BTB. It sits between branch resolution, at the predecode/execute stage, and the BTB write port. It compares each resolved control-flow instruction against what the BTB predicted, builds a field-masked update (valid/tag, 4-bit taken history, type, target), and queues it. It then drives the BTB `Up*` write interface at one update per cycle, honoring the BTB's one-cycle-delayed stop.

## Interface
Parameters:
- `DEPTH`, default 4: update queue entries; must be a power of 2, minimum 2.

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Rest`  in  1  reset, asynchronous, active-low.
- `BtbStop`  in  1  same stop signal the BTB receives.
- `ResAble`  in  1  resolved-branch record valid.
- `ResReady`  out  1  queue can accept; a record transfers when `ResAble & ResReady`.
- `ResPc`  in  32  PC of the fetch block holding the branch; only [31:5] is used.
- `ResHitBank`  in  2  `InstHitBanN` captured at prediction: 01 = bank0, 10 = bank1, 00 = miss.
- `ResType`  in  3  actual type (`TypeBRANCH`, `TypeFORMAL`, … from define.v).
- `ResTaken`  in  1  actual direction.
- `ResTarget`  in  32  actual target.
- `ResPredType`  in  3  predicted type.
- `ResPredTaken`  in  1  predicted direction.
- `ResPredTarget`  in  32  predicted target.
- `UpAble`  out  1  BTB write strobe.
- `UpAbleBank`  out  2  bank select; 00 means BTB chooses by its replacement counters.
- `UpPc`  out  32  {pc[31:5], 5'd0}.
- `UpCntAble`  out  1  enable for the history field.
- `UpCnt`  out  4  history value.
- `BtbUpTypeAble`  out  1  enable for the type field.
- `BtbUpType`  out  3  type value.
- `BtbUpTagetAble`  out  1  enable for the target field.
- `BtbUpTaget`  out  32  target value.

## Operation
Classification runs on the accepted record, with `CntV = ResTaken ? 4'b1111 : 4'b0000`:
- Miss (`ResHitBank == 00`):
  - If `ResTaken` is 1 or `ResType != TypeBRANCH`, allocate. Bank = 00, all three enables = 1, Cnt = CntV, type = `ResType`, target = `ResTarget`.
  - A not-taken BRANCH miss is dropped; nothing is enqueued.
- Hit (01 or 10): bank = `ResHitBank`.
  - `TypeAble = (ResType != ResPredType)`.
  - `TagetAble = ResTaken & (ResTarget != ResPredTarget)`.
  - `CntAble = (ResType == TypeBRANCH) & (ResTaken != ResPredTaken)`.
  - Value fields always carry the actual data (CntV, `ResType`, `ResTarget`).
  - If no enable is set, the record is dropped.
- `ResHitBank == 11` is illegal. It is treated as a hit on bank0 (bank 01), and the assertion bench flags it.

Queue behavior:
- Circular FIFO of `DEPTH` entries, 71 bits each: pc[31:5], bank, cnt, type, target, 3 enables. Read and write pointers are `log2(DEPTH)` bits and wrap naturally. An occupancy counter is `log2(DEPTH)+1` bits.
- `ResReady = (count != DEPTH)`. It depends only on count, not on a same-cycle pop, so a full queue never accepts even while draining.
- A dropped record still completes the handshake and does not change count.
- `StopQ` is `BtbStop` registered, which mirrors the BTB's internal stop delay.
- `UpAble = (count != 0) & ~StopQ`.
- All `Up*` data outputs come directly from the head entry register and are 0 when the queue is empty.
- Pop whenever `UpAble` is 1. Simultaneous push and pop leaves count unchanged.
- `BtbFlash` is not an input. Resolved updates are architectural and survive front-end flushes.

## Timing
- Reset (`Rest` low, asynchronous): count, pointers and `StopQ` go to 0 immediately. All outputs read 0 except `ResReady`, which reads 1. Entries held at reset are discarded; reset during a drain cancels the remaining updates.
- Latency: a record accepted at edge N appears on `Up*` with `UpAble` = 1 during cycle N+1, provided `StopQ` = 0. The BTB writes it at edge N+2.
- No bypass: an empty queue still costs one cycle.
- Throughput is 1 update per cycle. The order of `Up*` writes equals acceptance order.
- If `BtbStop` rises in cycle K, `UpAble` falls in cycle K+1 and stays low while `StopQ` = 1. The head entry holds; no update is lost.
- Accepting records continues during stop until the queue is full.

## Test plan
- Miss, taken BRANCH, `ResPc` = 0x1C000047, `ResTarget` = 0x1C000100 → the next cycle shows `UpAble` = 1, `UpAbleBank` = 00, `UpPc` = 0x1C000040, `UpCnt` = 1111, all three enables = 1, `BtbUpType` = `TypeBRANCH`. The queue is empty the following cycle.
- Hit bank 10, predicted taken, actual not taken, target equal → `UpAbleBank` = 10, `UpCntAble` = 1, `UpCnt` = 0000, `BtbUpTypeAble` = 0, `BtbUpTagetAble` = 0.
- Hit with correct type, direction and target, and a miss not-taken BRANCH → handshake completes, `UpAble` never rises, count stays 0.
- Hold `BtbStop` = 1 and push 5 valid records back-to-back → `ResReady` = 0 after the 4th; the 5th is held by the source. Release stop at cycle K → 4 updates appear in order in cycles K+1 through K+4, then the 5th is accepted and written.
- Simultaneous push and pop at count = 3 → count stays 3; `ResReady` remains 1. At count = 4 with a pop, `ResReady` is still 0 that cycle.
- Assert `Rest` low asynchronously mid-drain with 3 entries queued → `UpAble` goes to 0 before the next clock edge. After release there are no stale writes and `ResReady` = 1.

Source files
------------

// File: rtl/btb_update_gen.sv
// btb_update_gen
// Turns resolved control-flow records into field-masked BTB updates. It
// queues them in a small circular FIFO and sends them to the BTB write port
// at one update per cycle.
//
// Ports
//   Clk, Rest        clock (rising edge) / asynchronous active-low reset
//   BtbStop          BTB stall; registered here to match the BTB's own delay
//   ResAble/ResReady resolved-record handshake (transfer on ResAble & ResReady)
//   Res*             resolved record: fetch-block PC, hit bank seen at
//                    prediction, actual and predicted type/direction/target
//   UpAble           BTB write strobe
//   UpAbleBank       bank select (00 = BTB picks by replacement counters)
//   UpPc             fetch-block aligned PC
//   UpCntAble/UpCnt  history field enable / value
//   BtbUpType*       type field enable / value
//   BtbUpTaget*      target field enable / value
//
// DEPTH must be a power of two and at least 2.
// TypeBRANCH must match the conditional-branch encoding in the shared type defines.

module btb_update_gen #(
  parameter int          DEPTH      = 4,
  parameter logic [2:0]  TypeBRANCH = 3'd1
) (
  input  logic        Clk,
  input  logic        Rest,
  input  logic        BtbStop,
  input  logic        ResAble,
  output logic        ResReady,
  input  logic [31:0] ResPc,
  input  logic [1:0]  ResHitBank,
  input  logic [2:0]  ResType,
  input  logic        ResTaken,
  input  logic [31:0] ResTarget,
  input  logic [2:0]  ResPredType,
  input  logic        ResPredTaken,
  input  logic [31:0] ResPredTarget,
  output logic        UpAble,
  output logic [1:0]  UpAbleBank,
  output logic [31:0] UpPc,
  output logic        UpCntAble,
  output logic [3:0]  UpCnt,
  output logic        BtbUpTypeAble,
  output logic [2:0]  BtbUpType,
  output logic        BtbUpTagetAble,
  output logic [31:0] BtbUpTaget
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  // 71-bit queue entry
  typedef struct packed {
    logic [26:0] pc;
    logic [1:0]  bank;
    logic [3:0]  cnt;
    logic [2:0]  typ;
    logic [31:0] target;
    logic        cntAble;
    logic        typeAble;
    logic        tagetAble;
  } entry_t;

  entry_t         mem [DEPTH];
  entry_t         newEnt;
  entry_t         head;
  logic           keep;
  logic           push;
  logic           pop;
  logic           notEmpty;
  logic           stopQ;
  logic [AW-1:0]  wrPtr;
  logic [AW-1:0]  rdPtr;
  logic [AW:0]    count;

  // Offset within the fetch block never reaches the BTB.
  logic unusedPcLow;
  assign unusedPcLow = ^ResPc[4:0];

  // Classification of the record currently offered on the Res* port.
  always_comb begin
    newEnt        = '0;
    keep          = 1'b0;
    newEnt.pc     = ResPc[31:5];
    newEnt.cnt    = {4{ResTaken}};
    newEnt.typ    = ResType;
    newEnt.target = ResTarget;
    if (ResHitBank == 2'b00) begin
      // A not-taken conditional branch that missed is the BTB's default
      // prediction already, so there is nothing worth allocating.
      if (ResTaken || (ResType != TypeBRANCH)) begin
        keep             = 1'b1;
        newEnt.bank      = 2'b00;
        newEnt.cntAble   = 1'b1;
        newEnt.typeAble  = 1'b1;
        newEnt.tagetAble = 1'b1;
      end
    end else begin
      // 11 cannot come from a real lookup; steer it to bank0.
      newEnt.bank      = (ResHitBank == 2'b10) ? 2'b10 : 2'b01;
      newEnt.typeAble  = (ResType != ResPredType);
      newEnt.tagetAble = ResTaken & (ResTarget != ResPredTarget);
      newEnt.cntAble   = (ResType == TypeBRANCH) & (ResTaken != ResPredTaken);
      keep             = newEnt.typeAble | newEnt.tagetAble | newEnt.cntAble;
    end
  end

  // Ready is a function of occupancy only, so a full queue refuses even in
  // a cycle where the head is leaving.
  assign ResReady = (count != FULL);
  assign notEmpty = (count != '0);
  assign UpAble   = notEmpty & ~stopQ;
  assign pop      = UpAble;
  // Dropped records still complete the handshake but take no slot.
  assign push     = ResAble & ResReady & keep;

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      count <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      stopQ <= 1'b0;
    end else begin
      stopQ <= BtbStop;
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: the outputs are masked while count is 0.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wrPtr] <= newEnt;
    end
  end

  assign head = notEmpty ? mem[rdPtr] : '0;

  assign UpAbleBank     = head.bank;
  assign UpPc           = {head.pc, 5'd0};
  assign UpCntAble      = head.cntAble;
  assign UpCnt          = head.cnt;
  assign BtbUpTypeAble  = head.typeAble;
  assign BtbUpType      = head.typ;
  assign BtbUpTagetAble = head.tagetAble;
  assign BtbUpTaget     = head.target;

endmodule

// File: tb/tb_btb_update_gen.sv
// Scoreboard bench for btb_update_gen: the driver pushes the expected update
// from a reference model into a queue at acceptance, and the monitor pops and
// compares whenever the model says the BTB should be written.

module tb_btb_update_gen;

  localparam int         DEPTH      = 4;
  localparam logic [2:0] TypeBRANCH = 3'd1;

  logic        Clk = 1'b0;
  logic        Rest = 1'b0;
  logic        BtbStop = 1'b0;
  logic        ResAble = 1'b0;
  logic        ResReady;
  logic [31:0] ResPc = '0;
  logic [1:0]  ResHitBank = '0;
  logic [2:0]  ResType = '0;
  logic        ResTaken = 1'b0;
  logic [31:0] ResTarget = '0;
  logic [2:0]  ResPredType = '0;
  logic        ResPredTaken = 1'b0;
  logic [31:0] ResPredTarget = '0;
  logic        UpAble;
  logic [1:0]  UpAbleBank;
  logic [31:0] UpPc;
  logic        UpCntAble;
  logic [3:0]  UpCnt;
  logic        BtbUpTypeAble;
  logic [2:0]  BtbUpType;
  logic        BtbUpTagetAble;
  logic [31:0] BtbUpTaget;

  btb_update_gen #(.DEPTH(DEPTH), .TypeBRANCH(TypeBRANCH)) dut (
    .Clk(Clk), .Rest(Rest), .BtbStop(BtbStop),
    .ResAble(ResAble), .ResReady(ResReady),
    .ResPc(ResPc), .ResHitBank(ResHitBank), .ResType(ResType),
    .ResTaken(ResTaken), .ResTarget(ResTarget),
    .ResPredType(ResPredType), .ResPredTaken(ResPredTaken),
    .ResPredTarget(ResPredTarget),
    .UpAble(UpAble), .UpAbleBank(UpAbleBank), .UpPc(UpPc),
    .UpCntAble(UpCntAble), .UpCnt(UpCnt),
    .BtbUpTypeAble(BtbUpTypeAble), .BtbUpType(BtbUpType),
    .BtbUpTagetAble(BtbUpTagetAble), .BtbUpTaget(BtbUpTaget)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  hit;
    logic [2:0]  typ;
    logic        taken;
    logic [31:0] target;
    logic [2:0]  ptyp;
    logic        ptaken;
    logic [31:0] ptarget;
  } rec_t;

  // {bank, pc, cnt, cntAble, type, typeAble, target, tagetAble}
  logic [75:0] sb[$];
  int          compared = 0;
  int          errors = 0;
  bit          randStop = 0;
  logic        stopQm;

  always @(posedge Clk or negedge Rest) begin
    if (!Rest) stopQm <= 1'b0;
    else       stopQm <= BtbStop;
  end

  function automatic bit model(input rec_t r, output logic [75:0] e);
    logic [1:0]  bank;
    logic [3:0]  cnt;
    bit          ce, te, ge;
    logic [31:0] pcAl;
    pcAl = r.pc & 32'hFFFF_FFE0;
    cnt  = r.taken ? 4'hF : 4'h0;
    e    = '0;
    if (r.hit == 2'b00) begin
      if (!r.taken && r.typ == TypeBRANCH) return 0;
      bank = 2'b00; ce = 1; te = 1; ge = 1;
    end else begin
      bank = (r.hit == 2'b10) ? 2'b10 : 2'b01;
      te   = (r.typ != r.ptyp);
      ge   = r.taken && (r.target != r.ptarget);
      ce   = (r.typ == TypeBRANCH) && (r.taken != r.ptaken);
      if (!(ce || te || ge)) return 0;
    end
    e = {bank, pcAl, cnt, ce, r.typ, te, r.target, ge};
    return 1;
  endfunction

  task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
    compared++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic [75:0] act, e;
    bit expAble;
    forever begin
      @(negedge Clk);
      act = {UpAbleBank, UpPc, UpCnt, UpCntAble, BtbUpType, BtbUpTypeAble,
             BtbUpTaget, BtbUpTagetAble};
      if (!Rest) begin
        check("reset_upable", 76'(UpAble), 76'd0);
        check("reset_ready", 76'(ResReady), 76'd1);
        check("reset_data", act, 76'd0);
      end else begin
        check("ready", 76'(ResReady), 76'(sb.size() < DEPTH));
        expAble = (sb.size() != 0) && !stopQm;
        check("upable", 76'(UpAble), 76'(expAble));
        if (expAble) begin
          e = sb.pop_front();
          check("update", act, e);
        end else if (sb.size() == 0) begin
          check("empty_data", act, 76'd0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      if (randStop) BtbStop = ($urandom_range(3) == 0);
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic send(input rec_t r);
    bit          rdy;
    int          n;
    logic [75:0] e;
    ResAble       = 1'b1;
    ResPc         = r.pc;
    ResHitBank    = r.hit;
    ResType       = r.typ;
    ResTaken      = r.taken;
    ResTarget     = r.target;
    ResPredType   = r.ptyp;
    ResPredTaken  = r.ptaken;
    ResPredTarget = r.ptarget;
    n = 0;
    do begin
      if (randStop) BtbStop = ($urandom_range(3) == 0);
      @(negedge Clk);
      rdy = ResReady;
      @(posedge Clk);
      n++;
    end while (!rdy && n < 100);
    #1;
    if (!rdy) begin
      compared++;
      errors++;
      $display("FAIL handshake_timeout: ready stayed 0 for %0d cycles, expected 1", n);
    end else if (model(r, e)) begin
      sb.push_back(e);
    end
    ResAble = 1'b0;
  endtask

  function automatic rec_t mk(input logic [31:0] pc, input logic [1:0] hit,
                              input logic [2:0] typ, input logic taken,
                              input logic [31:0] target, input logic [2:0] ptyp,
                              input logic ptaken, input logic [31:0] ptarget);
    rec_t r;
    r.pc = pc; r.hit = hit; r.typ = typ; r.taken = taken; r.target = target;
    r.ptyp = ptyp; r.ptaken = ptaken; r.ptarget = ptarget;
    return r;
  endfunction

  function automatic rec_t rnd();
    rec_t r;
    r.pc      = $urandom;
    r.hit     = 2'($urandom_range(3));
    r.typ     = ($urandom_range(1) == 1) ? TypeBRANCH : 3'($urandom_range(7));
    r.taken   = 1'($urandom_range(1));
    r.target  = $urandom;
    r.ptyp    = ($urandom_range(1) == 1) ? r.typ : 3'($urandom_range(7));
    r.ptaken  = 1'($urandom_range(1));
    r.ptarget = ($urandom_range(1) == 1) ? r.target : $urandom;
    return r;
  endfunction

  task automatic drain();
    int n;
    BtbStop = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge Clk);
      #1;
      n++;
    end
    idle(2);
    check("drained", 76'(sb.size()), 76'd0);
  endtask

  initial begin
    idle(3);
    @(negedge Clk);
    Rest = 1'b1;
    @(posedge Clk);
    #1;

    // Miss, taken branch: allocate into bank chosen by the BTB.
    send(mk(32'h1C000047, 2'b00, TypeBRANCH, 1'b1, 32'h1C000100, 3'd0, 1'b0, 32'h0));
    idle(3);

    // Hit bank1, direction wrong only.
    send(mk(32'h00001234, 2'b10, TypeBRANCH, 1'b0, 32'h00002000, TypeBRANCH, 1'b1, 32'h00002000));
    idle(3);

    // Correct hit and not-taken branch miss are both dropped.
    send(mk(32'h00004000, 2'b01, TypeBRANCH, 1'b1, 32'h00005000, TypeBRANCH, 1'b1, 32'h00005000));
    send(mk(32'h00006000, 2'b00, TypeBRANCH, 1'b0, 32'h00007000, 3'd0, 1'b0, 32'h0));
    idle(3);

    // Illegal hit bank 11 steered to bank0.
    send(mk(32'h00008000, 2'b11, 3'd4, 1'b1, 32'h00009000, 3'd2, 1'b1, 32'h00009000));
    idle(3);

    // Stop held: four fill the queue, the fifth waits until stop is released.
    BtbStop = 1'b1;
    idle(2);
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(mk(32'h10000000 + 32'(i) * 32'h40, 2'b00, 3'd2, 1'b1,
                  32'h20000000 + 32'(i), 3'd0, 1'b0, 32'h0));
      end
      begin
        idle(10);
        BtbStop = 1'b0;
      end
    join
    idle(6);

    // Push and pop together at count 3.
    BtbStop = 1'b1;
    idle(1);
    for (int i = 0; i < 3; i++)
      send(mk(32'h30000000 + 32'(i) * 32'h20, 2'b00, 3'd3, 1'b0, 32'h40000000 + 32'(i), 3'd0, 1'b0, 32'h0));
    BtbStop = 1'b0;
    idle(1);
    for (int i = 0; i < 3; i++)
      send(mk(32'h50000000 + 32'(i) * 32'h20, 2'b01, 3'd5, 1'b1, 32'h60000000 + 32'(i), 3'd5, 1'b1, 32'h0));
    drain();

    // Asynchronous reset in the middle of a drain.
    BtbStop = 1'b1;
    idle(1);
    for (int i = 0; i < 3; i++)
      send(mk(32'h70000000 + 32'(i) * 32'h20, 2'b00, 3'd6, 1'b1, 32'h80000000 + 32'(i), 3'd0, 1'b0, 32'h0));
    BtbStop = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #3;
    Rest = 1'b0;
    #1;
    check("async_reset_upable", 76'(UpAble), 76'd0);
    check("async_reset_ready", 76'(ResReady), 76'd1);
    sb.delete();
    repeat (2) @(posedge Clk);
    #2;
    Rest = 1'b1;
    idle(4);

    // Randomized traffic with random stalls.
    randStop = 1;
    for (int i = 0; i < 300; i++) begin
      send(rnd());
      if ($urandom_range(3) == 0) idle($urandom_range(2));
    end
    randStop = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule
